present_nest_engine: RTL and testbench

- Parametrised successor of the nested-box ("present") solver.
- Accepts a stream of box sizes over a valid/ready handshake and stores up to N boxes.
- Computes the longest chain of strictly nestable boxes in convergent rotating-ring passes.
- Reports the chain length with an explicit done/valid handshake, so the board-level wrapper can drive the hex LEDs or a PIO from it.
- Adds two modes: optional 90-degree rotation of boxes, and non-strict (equal-edge) nesting.

---
 rtl/present_nest_engine.sv | 215 +++++++++++++++++++++
 tb/tb_present_nest_engine.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/present_nest_engine.sv
// present_nest_engine
//   Loads a set of boxes (width, height) over a valid/ready stream, keeps up
//   to N of them, and finds the longest chain of boxes where each box nests
//   inside the next one. The search runs as repeated passes over a rotating
//   ring. Each pass takes exactly N cycles, and the search ends after the
//   first pass that changes nothing.
//
// Ports
//   clk, rst        rising-edge clock, asynchronous active-low reset
//   in_valid/ready  box beat handshake; in_w/in_h box edges, in_last ends set
//   mode_rotate     boxes may be turned 90 degrees (latched on first beat)
//   mode_nonstrict  equal edges may nest (latched on first beat)
//   busy            a set is being loaded or computed
//   done            one-cycle pulse when result becomes valid
//   result_valid    result holds a valid answer
//   result          longest chain length
//   stored          boxes stored for the current set
//   overflow        more than N non-empty boxes were offered in this set
module present_nest_engine #(
  parameter int N  = 100,
  parameter int W  = 32,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_w,
  input  logic [W-1:0]  in_h,
  input  logic          in_last,
  input  logic          mode_rotate,
  input  logic          mode_nonstrict,
  output logic          busy,
  output logic          done,
  output logic          result_valid,
  output logic [CW-1:0] result,
  output logic [CW-1:0] stored,
  output logic          overflow
);

  typedef enum logic [1:0] {S_LOAD, S_COMPUTE, S_DONE} state_t;

  state_t        state;
  logic [W-1:0]  ent_w [N];
  logic [W-1:0]  ent_h [N];
  logic [CW-1:0] n_q   [N];
  logic [W-1:0]  ring_w [N];
  logic [W-1:0]  ring_h [N];
  logic [CW-1:0] ring_n [N];
  logic [N-1:0]  ring_v;
  logic          rot_q, ns_q, in_set, changed;
  logic [CW-1:0] cyc;

  logic          accept, first, rot_eff, zero_box, full, wr_en, ovf_nxt;
  logic [W-1:0]  box_w, box_h;
  logic [CW-1:0] st_base, st_nxt;

  logic [CW-1:0] n_nxt [N];
  logic [CW-1:0] head_inc, res_max;
  logic          step_chg;

  function automatic logic fits(input logic [W-1:0] aw, input logic [W-1:0] ah,
                                input logic [W-1:0] bw, input logic [W-1:0] bh,
                                input logic ns);
    if (ns) fits = (aw >= bw) && (ah >= bh) && ((aw > bw) || (ah > bh));
    else    fits = (aw > bw) && (ah > bh);
  endfunction

  // Beat decode. The first beat of a set starts from a cleared count.
  always_comb begin
    accept   = in_valid && in_ready;
    first    = !in_set;
    rot_eff  = first ? mode_rotate : rot_q;
    box_w    = in_w;
    box_h    = in_h;
    if (rot_eff && (in_h > in_w)) begin
      box_w = in_h;
      box_h = in_w;
    end
    zero_box = (in_w == '0) || (in_h == '0);
    st_base  = first ? '0 : stored;
    full     = (st_base == CW'(N));
    wr_en    = accept && !zero_box && !full;
    st_nxt   = st_base + CW'(wr_en);
    ovf_nxt  = (!first && overflow) || (accept && !zero_box && full);
  end

  // Every stored box is compared against the ring head in parallel. ring_n
  // holds a snapshot taken at pass start, so a pass extends chains by at
  // most one box.
  always_comb begin
    step_chg = 1'b0;
    res_max  = '0;
    head_inc = ring_n[0] + CW'(1);
    for (int unsigned i = 0; i < N; i++) begin
      n_nxt[i] = n_q[i];
      if (ring_v[0] && (CW'(i) < stored) &&
          fits(ent_w[i], ent_h[i], ring_w[0], ring_h[0], ns_q) &&
          (n_q[i] < head_inc)) begin
        n_nxt[i] = head_inc;
        step_chg = 1'b1;
      end
      if (n_nxt[i] > res_max) res_max = n_nxt[i];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= S_LOAD;
      in_ready     <= 1'b1;
      busy         <= 1'b0;
      done         <= 1'b0;
      result_valid <= 1'b0;
      overflow     <= 1'b0;
      result       <= '0;
      stored       <= '0;
      rot_q        <= 1'b0;
      ns_q         <= 1'b0;
      in_set       <= 1'b0;
      changed      <= 1'b0;
      cyc          <= '0;
      ring_v       <= '0;
      for (int unsigned i = 0; i < N; i++) begin
        ent_w[i]  <= '0;
        ent_h[i]  <= '0;
        n_q[i]    <= '0;
        ring_w[i] <= '0;
        ring_h[i] <= '0;
        ring_n[i] <= '0;
      end
    end else begin
      done <= 1'b0;
      unique case (state)
        S_LOAD, S_DONE: begin
          if (state == S_DONE) state <= S_LOAD;
          if (accept) begin
            in_set   <= 1'b1;
            stored   <= st_nxt;
            overflow <= ovf_nxt;
            if (first) begin
              rot_q        <= mode_rotate;
              ns_q         <= mode_nonstrict;
              result_valid <= 1'b0;
              busy         <= 1'b1;
            end
            for (int unsigned i = 0; i < N; i++) begin
              if (wr_en && (CW'(i) == st_base)) begin
                ent_w[i] <= box_w;
                ent_h[i] <= box_h;
              end
            end
            if (in_last) begin
              in_set <= 1'b0;
              if (st_nxt == '0) begin
                state        <= S_DONE;
                done         <= 1'b1;
                result       <= '0;
                result_valid <= 1'b1;
                busy         <= 1'b0;
              end else begin
                state    <= S_COMPUTE;
                in_ready <= 1'b0;
                cyc      <= '0;
                changed  <= 1'b0;
                // The box of this final beat is forwarded straight into the ring.
                for (int unsigned i = 0; i < N; i++) begin
                  ring_w[i] <= (wr_en && (CW'(i) == st_base)) ? box_w : ent_w[i];
                  ring_h[i] <= (wr_en && (CW'(i) == st_base)) ? box_h : ent_h[i];
                  ring_v[i] <= (CW'(i) < st_nxt);
                  ring_n[i] <= (CW'(i) < st_nxt) ? CW'(1) : '0;
                  n_q[i]    <= (CW'(i) < st_nxt) ? CW'(1) : '0;
                end
              end
            end
          end
        end

        S_COMPUTE: begin
          for (int unsigned i = 0; i < N; i++) n_q[i] <= n_nxt[i];
          // Rotate toward the head. After N steps the ring is aligned with
          // the entries again, so the next snapshot loads without an offset.
          for (int unsigned i = 0; i < N - 1; i++) begin
            ring_w[i] <= ring_w[i+1];
            ring_h[i] <= ring_h[i+1];
            ring_n[i] <= ring_n[i+1];
          end
          ring_w[N-1] <= ring_w[0];
          ring_h[N-1] <= ring_h[0];
          ring_n[N-1] <= ring_n[0];
          ring_v      <= {ring_v[0], ring_v[N-1:1]};
          if (cyc == CW'(N - 1)) begin
            cyc     <= '0;
            changed <= 1'b0;
            if (changed || step_chg) begin
              for (int unsigned i = 0; i < N; i++) ring_n[i] <= n_nxt[i];
            end else begin
              state        <= S_DONE;
              done         <= 1'b1;
              result       <= res_max;
              result_valid <= 1'b1;
              busy         <= 1'b0;
              in_ready     <= 1'b1;
            end
          end else begin
            cyc     <= cyc + CW'(1);
            changed <= changed || step_chg;
          end
        end

        default: state <= S_LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_present_nest_engine.sv
module tb_present_nest_engine;
  localparam int N  = 4;
  localparam int W  = 8;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_w, in_h;
  logic          in_last;
  logic          mode_rotate, mode_nonstrict;
  logic          busy, done, result_valid, overflow;
  logic [CW-1:0] result, stored;

  int checks = 0;
  int errors = 0;

  int bw[$];
  int bh[$];
  int brot[$];
  int bns[$];

  present_nest_engine #(.N(N), .W(W), .CW(CW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_w(in_w), .in_h(in_h), .in_last(in_last),
    .mode_rotate(mode_rotate), .mode_nonstrict(mode_nonstrict),
    .busy(busy), .done(done), .result_valid(result_valid),
    .result(result), .stored(stored), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic bit fits_ref(input int aw, input int ah, input int cw, input int ch, input int ns);
    if (ns != 0) return (aw >= cw) && (ah >= ch) && ((aw > cw) || (ah > ch));
    return (aw > cw) && (ah > ch);
  endfunction

  // Longest chain by ordering boxes on edge sum (a nesting box always has
  // the larger sum) and a longest-path scan over that order.
  task automatic model(output int st, output int ov, output int res);
    int aw[$];
    int ah[$];
    int dp[$];
    int w, h, t;
    ov = 0;
    res = 0;
    foreach (bw[k]) begin
      w = bw[k];
      h = bh[k];
      if (w == 0 || h == 0) continue;
      if (brot[0] != 0 && h > w) begin t = w; w = h; h = t; end
      if (aw.size() < N) begin aw.push_back(w); ah.push_back(h); end
      else ov = 1;
    end
    st = aw.size();
    for (int a = 0; a < st; a++)
      for (int b = 0; b < st - 1 - a; b++)
        if (aw[b] + ah[b] > aw[b+1] + ah[b+1]) begin
          t = aw[b]; aw[b] = aw[b+1]; aw[b+1] = t;
          t = ah[b]; ah[b] = ah[b+1]; ah[b+1] = t;
        end
    for (int i = 0; i < st; i++) begin
      dp.push_back(1);
      for (int j = 0; j < i; j++)
        if (fits_ref(aw[i], ah[i], aw[j], ah[j], bns[0]) && dp[j] + 1 > dp[i]) dp[i] = dp[j] + 1;
      if (dp[i] > res) res = dp[i];
    end
  endtask

  task automatic clr();
    bw.delete(); bh.delete(); brot.delete(); bns.delete();
  endtask

  task automatic add(input int w, input int h, input int r, input int ns);
    bw.push_back(w); bh.push_back(h); brot.push_back(r); bns.push_back(ns);
  endtask

  task automatic send_beats(input string tag);
    for (int k = 0; k < bw.size(); k++) begin
      @(negedge clk);
      if (k == 0) chk({tag, "_ready_load"}, in_ready, 1);
      in_valid       = 1'b1;
      in_w           = W'(bw[k]);
      in_h           = W'(bh[k]);
      in_last        = (k == bw.size() - 1);
      mode_rotate    = brot[k][0];
      mode_nonstrict = bns[k][0];
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_last  = 1'b0;
      if (k == 0 && bw.size() > 1) begin
        chk({tag, "_busy_load"}, busy, 1);
        chk({tag, "_rv_clear"}, result_valid, 0);
      end
    end
  endtask

  task automatic run_set(input string tag);
    int st, ov, res, lat, exp_lat;
    model(st, ov, res);
    send_beats(tag);
    if (st > 0) begin
      chk({tag, "_ready_compute"}, in_ready, 0);
      chk({tag, "_busy_compute"}, busy, 1);
    end
    lat = 0;
    while (done !== 1'b1 && lat < 2000) begin
      @(posedge clk);
      #1;
      lat++;
    end
    exp_lat = (st == 0) ? 0 : res * N;
    chk({tag, "_done"}, done, 1);
    chk({tag, "_latency"}, lat, exp_lat);
    chk({tag, "_result"}, result, res);
    chk({tag, "_rv"}, result_valid, 1);
    chk({tag, "_stored"}, stored, st);
    chk({tag, "_overflow"}, overflow, ov);
    chk({tag, "_busy_done"}, busy, 0);
    chk({tag, "_ready_done"}, in_ready, 1);
    @(posedge clk);
    #1;
    chk({tag, "_done_pulse"}, done, 0);
    chk({tag, "_result_hold"}, result, res);
    chk({tag, "_rv_hold"}, result_valid, 1);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_in_ready"}, in_ready, 1);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_rv"}, result_valid, 0);
    chk({tag, "_result"}, result, 0);
    chk({tag, "_stored"}, stored, 0);
    chk({tag, "_overflow"}, overflow, 0);
  endtask

  initial begin
    rst = 1'b0;
    in_valid = 1'b0; in_w = '0; in_h = '0; in_last = 1'b0;
    mode_rotate = 1'b0; mode_nonstrict = 1'b0;
    #12;
    chk_reset_vals("reset");
    @(negedge clk);
    rst = 1'b1;

    clr(); add(3,3,0,0); add(2,2,0,0); add(1,1,0,0);
    run_set("chain3");

    clr(); add(2,5,0,0); add(6,3,0,0); add(1,1,0,0);
    run_set("norot");
    clr(); add(2,5,1,0); add(6,3,1,0); add(1,1,1,0);
    run_set("rot");

    clr(); add(2,2,0,0); add(2,3,0,0); add(2,3,0,0);
    run_set("strict_eq");
    clr(); add(2,2,0,1); add(2,3,0,1); add(2,3,0,1);
    run_set("nonstrict_eq");

    clr(); add(6,6,0,0); add(5,5,0,0); add(4,4,0,0); add(3,3,0,0); add(2,2,0,0); add(1,1,0,0);
    run_set("overflow");

    clr(); add(0,5,0,0);
    run_set("zero_only");

    clr(); add(2,5,1,0); add(6,3,0,1); add(1,1,0,1);
    run_set("mode_toggle_a");
    clr(); add(2,5,0,0); add(6,3,1,1); add(1,1,1,1);
    run_set("mode_toggle_b");

    // Abort during compute, then rerun the same set.
    clr(); add(3,3,0,0); add(2,2,0,0); add(1,1,0,0);
    send_beats("abort");
    repeat (5) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk_reset_vals("abort_rst");
    @(negedge clk);
    rst = 1'b1;
    run_set("rerun");

    for (int s = 0; s < 25; s++) begin
      int nb;
      int r;
      int ns;
      clr();
      nb = $urandom_range(1, 6);
      r  = $urandom_range(0, 1);
      ns = $urandom_range(0, 1);
      for (int k = 0; k < nb; k++)
        add($urandom_range(0, 7), $urandom_range(0, 7),
            (k == 0) ? r : $urandom_range(0, 1), (k == 0) ? ns : $urandom_range(0, 1));
      run_set($sformatf("rand%0d", s));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    errors++;
    $display("FAIL timeout: simulation did not finish");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "timeout");
  end
endmodule
